alu_rr_scheduler: RTL

- Shares one registered 4-bit ALU (add/mul/or/and) among N_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU operand/opcode inputs, waits out the fixed ALU latency, captures the result and returns it on a single tagged response channel with valid/ready.
- Sits between requesting blocks and the shared ALU instance.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_rr_scheduler_arbiter.sv | 31 +++
 rtl/alu_rr_scheduler.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin scheduler: ALU opcodes and FSM state encodings.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_valid
);

    logic [IW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among N_REQ requesters: round-robin accept, wait out the ALU
// latency, then return the tagged result on a valid/ready response channel.
module alu_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DW      = 4,
    parameter int RW      = 8,
    parameter int ALU_LAT = 2,
    parameter int IW      = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    input  logic [N_REQ*2-1:0]  req_op,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [1:0]          alu_opcode,
    input  logic [RW-1:0]       alu_result,
    output logic                rsp_valid,
    output logic [IW-1:0]       rsp_id,
    output logic [RW-1:0]       rsp_data,
    input  logic                rsp_ready,
    output logic                busy
);

    import alu_pkg::*;

    localparam int CW = $clog2(ALU_LAT + 1);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic [N_REQ-1:0]  grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_valid;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .IW   (IW)
    ) u_arb (
        .req        (req_valid),
        .ptr        (ptr),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // Grants are only offered while idle and out of reset, so an accept always means a transfer.
    assign req_ready = (rst && state == S_IDLE) ? grant : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        alu_a      <= req_a[int'(grant_idx)*DW +: DW];
                        alu_b      <= req_b[int'(grant_idx)*DW +: DW];
                        alu_opcode <= req_op[int'(grant_idx)*2 +: 2];
                        rsp_id     <= grant_idx;
                        ptr        <= (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                        cnt        <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The ALU result becomes valid ALU_LAT edges after the operands were latched.
                    if (cnt == CW'(ALU_LAT)) begin
                        rsp_data  <= alu_result;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
